// File: rtl/tri_port_merge_pkg.sv
// tri_merge_pkg: shared widths, port types and round-robin helper for tri_port_merge
package tri_merge_pkg;
  localparam int DW = 8;
  localparam int NPORT = 3;
  typedef struct packed {
    logic          wen;
    logic [DW-1:0] data;
  } joined_t;
  typedef logic [1:0] port_idx_t;
  function automatic port_idx_t rr_next(port_idx_t p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/tri_port_merge_if.sv
// tri_port_merge_if: three write ports in, merged stream and per-port status out
interface tri_port_merge_if;
  import tri_merge_pkg::*;
  logic             wen0, wen1, wen2;
  logic [DW-1:0]    i_data0, i_data1, i_data2;
  logic             valid;
  logic [DW-1:0]    o_data;
  logic [NPORT-1:0] full_o, ovf_o;
  modport master (
    output wen0, wen1, wen2, i_data0, i_data1, i_data2,
    input  valid, o_data, full_o, ovf_o
  );
  modport slave (
    input  wen0, wen1, wen2, i_data0, i_data1, i_data2,
    output valid, o_data, full_o, ovf_o
  );
endinterface

// File: rtl/tri_port_merge_fifo.sv
// merge_fifo: synchronous FIFO with extra-MSB pointers and combinational head
module merge_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]   wp, rp;
  logic [DW-1:0] mem [DEPTH];
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign head  = mem[rp[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/tri_port_merge.sv
// tri_port_merge: three buffered write ports merged round-robin into one registered stream
module tri_port_merge
  import tri_merge_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int NPORT = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic freeze_i,
  tri_port_merge_if.slave bus
);
  joined_t          wr [NPORT];
  logic [DW-1:0]    head [NPORT];
  logic [NPORT-1:0] full, empty, push, pop, drop, ovf_q;
  port_idx_t        rr, n1, n2, grant;
  logic             run, any, valid_q;
  logic [DW-1:0]    data_q, hd;
  assign wr[0] = '{wen: bus.wen0, data: bus.i_data0};
  assign wr[1] = '{wen: bus.wen1, data: bus.i_data1};
  assign wr[2] = '{wen: bus.wen2, data: bus.i_data2};
  assign run   = !freeze_i;
  assign any   = ~&empty;
  assign n1    = rr_next(rr);
  assign n2    = rr_next(n1);
  // grant is decided on pre-edge occupancy, so fresh pushes wait one cycle
  assign grant = !empty[rr] ? rr : !empty[n1] ? n1 : n2;
  assign hd    = grant == 2'd2 ? head[2] : grant == 2'd1 ? head[1] : head[0];
  genvar k;
  generate
    for (k = 0; k < NPORT; k++) begin : g_port
      assign pop[k]  = run && any && grant == port_idx_t'(k);
      assign push[k] = run && wr[k].wen && (!full[k] || pop[k]);
      assign drop[k] = run && wr[k].wen && full[k] && !pop[k];
      merge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (push[k]),
        .pop     (pop[k]),
        .din     (wr[k].data),
        .full    (full[k]),
        .empty   (empty[k]),
        .head    (head[k])
      );
    end
  endgenerate
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= '0;
      rr      <= '0;
    end else if (run) begin
      valid_q <= any;
      ovf_q   <= ovf_q | drop;
      if (any) begin
        data_q <= hd;
        rr     <= rr_next(grant);
      end
    end
  end
  assign bus.valid  = valid_q;
  assign bus.o_data = data_q;
  assign bus.full_o = full;
  assign bus.ovf_o  = ovf_q;
endmodule

// File: tb/tb_tri_port_merge.sv
// tb_tri_port_merge: directed checks of reset, merge order, overflow, freeze and mid-run reset
module tb_tri_port_merge;
  logic clk_i = 1'b0;
  logic rst_n_i, freeze_i;
  int tests = 0;
  int fails = 0;
  logic [7:0] exp_o [14];
  tri_port_merge_if bus();
  tri_port_merge #(.DW(8), .DEPTH(4), .NPORT(3)) dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .freeze_i (freeze_i),
    .bus      (bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic out(input string tag, input logic v, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(bus.valid), 32'(v));
    chk({tag, "_data"}, 32'(bus.o_data), 32'(d));
  endtask
  task automatic wr(input logic [2:0] en, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    bus.wen0 = en[0];
    bus.wen1 = en[1];
    bus.wen2 = en[2];
    bus.i_data0 = d0;
    bus.i_data1 = d1;
    bus.i_data2 = d2;
  endtask
  initial begin
    exp_o = '{8'hA0, 8'hB0, 8'hC0, 8'hA1, 8'hB1, 8'hC1, 8'hA2,
              8'hB2, 8'hC2, 8'hA3, 8'hB3, 8'hC3, 8'hB4, 8'hB5};
    rst_n_i = 1'b0;
    freeze_i = 1'b0;
    wr(3'b000, 8'h00, 8'h00, 8'h00);
    tick;
    tick;
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      out("idle", 1'b0, 8'h00);
      chk("idle_full", 32'(bus.full_o), 32'd0);
      chk("idle_ovf", 32'(bus.ovf_o), 32'd0);
    end
    wr(3'b001, 8'hA5, 8'h00, 8'h00);
    tick;
    wr(3'b000, 8'h00, 8'h00, 8'h00);
    out("single_push", 1'b0, 8'h00);
    tick;
    out("single_out", 1'b1, 8'hA5);
    tick;
    out("single_idle", 1'b0, 8'hA5);
    rst_n_i = 1'b0;
    tick;
    rst_n_i = 1'b1;
    wr(3'b111, 8'h11, 8'h22, 8'h33);
    tick;
    wr(3'b000, 8'h00, 8'h00, 8'h00);
    out("burst1_push", 1'b0, 8'h00);
    tick;
    out("burst1_w0", 1'b1, 8'h11);
    tick;
    out("burst1_w1", 1'b1, 8'h22);
    tick;
    out("burst1_w2", 1'b1, 8'h33);
    wr(3'b111, 8'h44, 8'h55, 8'h66);
    tick;
    wr(3'b000, 8'h00, 8'h00, 8'h00);
    out("burst2_push", 1'b0, 8'h33);
    tick;
    out("burst2_w0", 1'b1, 8'h44);
    tick;
    out("burst2_w1", 1'b1, 8'h55);
    tick;
    out("burst2_w2", 1'b1, 8'h66);
    // port 1 writes 7 times while ports 0 and 2 keep the arbiter busy
    for (int e = 1; e <= 16; e++) begin
      wr({e <= 4, e <= 7, e <= 4}, 8'(8'hA0 + e - 1), 8'(8'hB0 + e - 1), 8'(8'hC0 + e - 1));
      tick;
      if (e == 1) out("ovf_first", 1'b0, 8'h66);
      else if (e <= 15) out("ovf_stream", 1'b1, exp_o[e-2]);
      else out("ovf_drain", 1'b0, 8'hB5);
      if (e == 4) chk("ovf_full_e4", 32'(bus.full_o), 32'd0);
      if (e == 5) chk("ovf_full_e5", 32'(bus.full_o), 32'd2);
      if (e == 6) chk("ovf_none_e6", 32'(bus.ovf_o), 32'd0);
      if (e == 7) chk("ovf_set_e7", 32'(bus.ovf_o), 32'd2);
    end
    chk("ovf_sticky", 32'(bus.ovf_o), 32'd2);
    wr(3'b011, 8'hD1, 8'hE1, 8'h00);
    tick;
    out("frz_pre1", 1'b0, 8'hB5);
    wr(3'b100, 8'h00, 8'h00, 8'hF1);
    tick;
    out("frz_pre2", 1'b1, 8'hD1);
    wr(3'b001, 8'h77, 8'h00, 8'h00);
    freeze_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      out("frz_hold", 1'b1, 8'hD1);
      chk("frz_ovf", 32'(bus.ovf_o), 32'd2);
      chk("frz_full", 32'(bus.full_o), 32'd0);
    end
    freeze_i = 1'b0;
    wr(3'b000, 8'h00, 8'h00, 8'h00);
    tick;
    out("frz_rel0", 1'b1, 8'hE1);
    tick;
    out("frz_rel1", 1'b1, 8'hF1);
    tick;
    out("frz_done", 1'b0, 8'hF1);
    wr(3'b001, 8'h80, 8'h00, 8'h00);
    tick;
    out("rst_pre1", 1'b0, 8'hF1);
    wr(3'b111, 8'h81, 8'h82, 8'h83);
    tick;
    out("rst_pre2", 1'b1, 8'h80);
    wr(3'b000, 8'h00, 8'h00, 8'h00);
    rst_n_i = 1'b0;
    freeze_i = 1'b1;
    tick;
    out("rst_mid", 1'b0, 8'h00);
    chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    rst_n_i = 1'b1;
    freeze_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      out("rst_flushed", 1'b0, 8'h00);
    end
    wr(3'b111, 8'h91, 8'h92, 8'h93);
    tick;
    wr(3'b000, 8'h00, 8'h00, 8'h00);
    out("rst_rr_push", 1'b0, 8'h00);
    tick;
    out("rst_rr_w0", 1'b1, 8'h91);
    tick;
    out("rst_rr_w1", 1'b1, 8'h92);
    tick;
    out("rst_rr_w2", 1'b1, 8'h93);
    tick;
    out("rst_rr_idle", 1'b0, 8'h93);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
